// File: rtl/tea_byte_frontend.sv
// Byte-serial front end for the combinational TEA core: packs bytes into keys/blocks,
// sequences the two-cycle key load, runs one block per COMPUTE and streams the result out.
//
// state   | meaning
// COLLECT | accepting input bytes into the shift buffer
// KEY_HI  | writekey high, upper key half on core_in
// KEY_LO  | writekey low, lower key half on core_in (core latches it)
// COMPUTE | block and mode on the core, result captured at the edge
// DRAIN   | streaming the 8 result bytes out, MSB byte first
module tea_byte_frontend (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        s_key,
   input  logic        s_mode,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] core_in,
   output logic        core_writekey,
   output logic        core_mode,
   input  logic [63:0] core_out,
   output logic        key_loaded,
   output logic        drop
);

   typedef enum logic [2:0] {
      COLLECT,
      KEY_HI,
      KEY_LO,
      COMPUTE,
      DRAIN
   } state_t;

   state_t         state;
   logic [127:0]   shift_q;
   logic [3:0]     byte_cnt;
   logic [2:0]     out_cnt;
   logic           group_key;
   logic           mode_q;
   logic [63:0]    out_q;
   logic [63:0]    core_in_q;
   logic           key_loaded_q;
   logic           drop_q;
   logic           s_ready_q;
   logic           m_valid_q;
   logic           writekey_q;

   logic [127:0]   shift_next;
   logic           key_group_now;

   assign shift_next    = {shift_q[119:0], s_data};
   // group type is only known from s_key itself on the first byte
   assign key_group_now = (byte_cnt == 4'd0) ? s_key : group_key;

   // s_ready is gated by rst so it reads 0 for the whole reset cycle
   assign s_ready       = s_ready_q & ~rst;
   assign m_valid       = m_valid_q;
   assign m_data        = out_q[63:56];
   assign core_in       = core_in_q;
   assign core_writekey = writekey_q;
   assign core_mode     = mode_q;
   assign key_loaded    = key_loaded_q;
   assign drop          = drop_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= COLLECT;
         shift_q      <= '0;
         byte_cnt     <= '0;
         out_cnt      <= '0;
         group_key    <= 1'b0;
         mode_q       <= 1'b0;
         out_q        <= '0;
         core_in_q    <= '0;
         key_loaded_q <= 1'b0;
         drop_q       <= 1'b0;
         s_ready_q    <= 1'b1;
         m_valid_q    <= 1'b0;
         writekey_q   <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state)
            COLLECT: begin
               if (s_valid && s_ready_q) begin
                  shift_q <= shift_next;
                  if (byte_cnt == 4'd0) begin
                     group_key <= s_key;
                     mode_q    <= s_mode;
                  end
                  if (key_group_now && byte_cnt == 4'd15) begin
                     byte_cnt     <= '0;
                     core_in_q    <= shift_next[127:64];
                     writekey_q   <= 1'b1;
                     key_loaded_q <= 1'b0;
                     s_ready_q    <= 1'b0;
                     state        <= KEY_HI;
                  end else if (!key_group_now && byte_cnt == 4'd7) begin
                     byte_cnt <= '0;
                     if (key_loaded_q) begin
                        core_in_q <= shift_next[63:0];
                        s_ready_q <= 1'b0;
                        state     <= COMPUTE;
                     end else begin
                        drop_q <= 1'b1;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 4'd1;
                  end
               end
            end
            KEY_HI: begin
               writekey_q <= 1'b0;
               core_in_q  <= shift_q[63:0];
               state      <= KEY_LO;
            end
            KEY_LO: begin
               key_loaded_q <= 1'b1;
               s_ready_q    <= 1'b1;
               state        <= COLLECT;
            end
            COMPUTE: begin
               out_q     <= core_out;
               m_valid_q <= 1'b1;
               state     <= DRAIN;
            end
            DRAIN: begin
               if (m_ready) begin
                  out_q <= {out_q[55:0], 8'h00};
                  if (out_cnt == 3'd7) begin
                     out_cnt   <= '0;
                     m_valid_q <= 1'b0;
                     s_ready_q <= 1'b1;
                     state     <= COLLECT;
                  end else begin
                     out_cnt <= out_cnt + 3'd1;
                  end
               end
            end
            default: begin
               state <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tea_byte_frontend.sv
// Directed bench for tea_byte_frontend; a behavioural TEA core answers core_in/core_writekey.
module tb_tea_byte_frontend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_key = 1'b0;
   logic        s_mode = 1'b0;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [63:0] core_in;
   logic        core_writekey;
   logic        core_mode;
   logic [63:0] core_out;
   logic        key_loaded;
   logic        drop;

   int n_cmp = 0;
   int n_bad = 0;
   int wk_count = 0;
   int mv_count = 0;
   int drop_count = 0;

   always #5 clk = ~clk;

   tea_byte_frontend dut (
      .clk(clk), .rst(rst),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_mode(s_mode),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .core_in(core_in), .core_writekey(core_writekey), .core_mode(core_mode), .core_out(core_out),
      .key_loaded(key_loaded), .drop(drop)
   );

   function automatic logic [63:0] tea_fn(input logic [63:0] blk, input logic md, input logic [127:0] k);
      logic [31:0] v0, v1, sum, k0, k1, k2, k3;
      v0 = blk[63:32]; v1 = blk[31:0];
      k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
      if (!md) begin
         sum = 32'h0;
         for (int i = 0; i < 32; i++) begin
            sum = sum + 32'h9e3779b9;
            v0 = v0 + (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            v1 = v1 + (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
         end
      end else begin
         sum = 32'hc6ef3720;
         for (int i = 0; i < 32; i++) begin
            v1 = v1 - (((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3));
            v0 = v0 - (((v1 << 4) + k0) ^ (v1 + sum) ^ ((v1 >> 5) + k1));
            sum = sum - 32'h9e3779b9;
         end
      end
      return {v0, v1};
   endfunction

   // core model: upper half latched while writekey is high, lower half on the following edge
   logic [127:0] core_key = '0;
   logic         wk_d = 1'b0;
   always @(posedge clk) begin
      if (core_writekey) core_key[127:64] <= core_in;
      else if (wk_d)     core_key[63:0]   <= core_in;
      wk_d <= core_writekey;
      if (core_writekey) wk_count <= wk_count + 1;
      if (m_valid)       mv_count <= mv_count + 1;
      if (drop)          drop_count <= drop_count + 1;
   end
   assign core_out = tea_fn(core_in, core_mode, core_key);

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic k, input logic md);
      int guard = 0;
      @(negedge clk);
      s_valid = 1'b1; s_data = b; s_key = k; s_mode = md;
      while (s_ready !== 1'b1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) check_val("send_timeout", {127'd0, s_ready}, 128'd1);
      @(posedge clk);
   endtask

   // later bytes carry inverted s_key/s_mode, which must be ignored
   task automatic send_group(input logic [127:0] v, input int nb, input logic k, input logic md);
      for (int i = 0; i < nb; i++)
         send_byte(v[127-8*i -: 8], (i == 0) ? k : ~k, (i == 0) ? md : ~md);
   endtask

   task automatic recv_block(input bit stall, output logic [63:0] got, output int waits);
      int n = 0, guard = 0, stable_err = 0, sready_err = 0, forced = 0;
      logic [7:0] held = 8'h00;
      bit stalled = 1'b0;
      got = '0; waits = 0;
      while (n < 8 && guard < 600) begin
         @(negedge clk);
         guard++;
         if (m_valid !== 1'b1) begin
            if (n == 0) waits++;
            m_ready = 1'b0;
         end else begin
            if (stalled && m_data !== held) stable_err++;
            if (s_ready !== 1'b0) sready_err++;
            if (!stall) m_ready = 1'b1;
            else if (n == 2 && forced < 15) begin m_ready = 1'b0; forced++; end
            else m_ready = ($urandom_range(0, 2) == 0);
            held = m_data;
            stalled = !m_ready;
            if (m_ready) begin got = {got[55:0], m_data}; n++; end
         end
      end
      @(posedge clk);
      #1 m_ready = 1'b0;
      check_val("recv_count", n, 8);
      check_val("stall_stable", stable_err, 0);
      check_val("s_ready_in_drain", sready_err, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_s_ready"}, s_ready, 0);
      check_val({tag, "_m_valid"}, m_valid, 0);
      check_val({tag, "_m_data"}, m_data, 0);
      check_val({tag, "_core_in"}, core_in, 0);
      check_val({tag, "_writekey"}, core_writekey, 0);
      check_val({tag, "_core_mode"}, core_mode, 0);
      check_val({tag, "_key_loaded"}, key_loaded, 0);
      check_val({tag, "_drop"}, drop, 0);
   endtask

   task automatic drop_block(input string tag, input logic [127:0] v);
      int wk0, mv0, dr0;
      wk0 = wk_count; mv0 = mv_count; dr0 = drop_count;
      send_group(v, 8, 1'b0, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      check_val({tag, "_drop_pulse"}, drop, 1);
      check_val({tag, "_s_ready"}, s_ready, 1);
      @(negedge clk);
      check_val({tag, "_drop_clear"}, drop, 0);
      repeat (4) @(negedge clk);
      check_val({tag, "_drop_once"}, drop_count - dr0, 1);
      check_val({tag, "_no_m_valid"}, mv_count - mv0, 0);
      check_val({tag, "_no_writekey"}, wk_count - wk0, 0);
   endtask

   task automatic load_zero_key();
      send_group('0, 16, 1'b1, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      check_val("zk_n1_writekey", core_writekey, 1);
      check_val("zk_n1_key_loaded", key_loaded, 0);
      @(negedge clk);
      check_val("zk_n2_writekey", core_writekey, 0);
      check_val("zk_n2_key_loaded", key_loaded, 0);
      @(negedge clk);
      check_val("zk_n3_key_loaded", key_loaded, 1);
      check_val("zk_n3_s_ready", s_ready, 1);
   endtask

   logic [63:0] got;
   int waits, wk0;

   initial begin
      // reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_s_ready_after", s_ready, 1);

      // data before any key
      drop_block("nokey", {64'h0011223344556677, 64'h0});

      // zero key, encrypt zero block
      load_zero_key();
      send_group('0, 8, 1'b0, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      check_val("enc_compute_m_valid", m_valid, 0);
      check_val("enc_compute_s_ready", s_ready, 0);
      check_val("enc_compute_core_in", core_in, 64'h0);
      check_val("enc_compute_mode", core_mode, 0);
      recv_block(1'b0, got, waits);
      check_val("enc_latency", waits, 0);
      check_val("enc_result", got, 64'h41ea3a0a94baa940);
      @(negedge clk);
      check_val("enc_after_m_valid", m_valid, 0);
      check_val("enc_after_s_ready", s_ready, 1);

      // decrypt with m_ready stalls, next key's first byte held on s_valid
      send_group({64'h41ea3a0a94baa940, 64'h0}, 8, 1'b0, 1'b1);
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'h00; s_key = 1'b1; s_mode = 1'b0;
      check_val("dec_compute_mode", core_mode, 1);
      check_val("dec_compute_core_in", core_in, 64'h41ea3a0a94baa940);
      check_val("dec_compute_s_ready", s_ready, 0);
      recv_block(1'b1, got, waits);
      check_val("dec_result", got, 64'h0);
      @(negedge clk);
      check_val("dec_after_m_valid", m_valid, 0);
      check_val("dec_after_s_ready", s_ready, 1);
      @(posedge clk);

      // remaining bytes of key 00 01 .. 0f
      wk0 = wk_count;
      for (int i = 1; i < 16; i++) send_byte(i[7:0], 1'b0, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      check_val("k16_hi_writekey", core_writekey, 1);
      check_val("k16_hi_core_in", core_in, 64'h0001020304050607);
      check_val("k16_hi_key_loaded", key_loaded, 0);
      @(negedge clk);
      check_val("k16_lo_writekey", core_writekey, 0);
      check_val("k16_lo_core_in", core_in, 64'h08090a0b0c0d0e0f);
      @(negedge clk);
      check_val("k16_key_loaded", key_loaded, 1);
      check_val("k16_core_in_held", core_in, 64'h08090a0b0c0d0e0f);
      check_val("k16_writekey_cycles", wk_count - wk0, 1);

      // reset after 5 bytes of a data group
      send_group({64'h0102030405060708, 64'h0}, 5, 1'b0, 1'b1);
      @(negedge clk); s_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      @(negedge clk);
      check_val("midrst_s_ready_after", s_ready, 1);
      drop_block("postrst", {64'h8899aabbccddeeff, 64'h0});

      // rekey and confirm the block path works again
      load_zero_key();
      send_group('0, 8, 1'b0, 1'b0);
      @(negedge clk); s_valid = 1'b0;
      recv_block(1'b0, got, waits);
      check_val("rekey_latency", waits, 0);
      check_val("rekey_result", got, 64'h41ea3a0a94baa940);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
